// File: rtl/buff_load_scheduler.sv
// Routes one upstream DMA stream into Num_Dst destination streams, serving each in ascending order for its beat count.
// SCAN costs one cycle per index; ROUTE passes valid/ready straight through at one beat per cycle.
module buff_load_scheduler #(
  parameter int Axi_Width = 64,
  parameter int Num_Dst   = 4,
  parameter int Cnt_Width = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           layer_start,
  input  logic [Num_Dst*Cnt_Width-1:0]   beat_cnt,
  input  logic [Axi_Width-1:0]           s_axis_tdata,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  output logic [Axi_Width-1:0]           m_axis_tdata,
  output logic [Num_Dst-1:0]             m_axis_tvalid,
  input  logic [Num_Dst-1:0]             m_axis_tready,
  output logic [Num_Dst-1:0]             m_axis_tlast,
  output logic [$clog2(Num_Dst+1)-1:0]   dst_sel,
  output logic                           busy,
  output logic                           layer_done
);

  localparam int Idx_W = $clog2(Num_Dst + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_ROUTE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                       r_state;
  logic [Idx_W-1:0]             r_idx;
  logic [Num_Dst*Cnt_Width-1:0] r_cnt;
  logic [Cnt_Width-1:0]         r_remain;

  logic [Num_Dst-1:0]           w_sel;
  logic [Cnt_Width-1:0]         w_cur_cnt;
  logic                         w_route;
  logic                         w_hs;
  logic                         w_last_beat;
  logic                         w_idx_end;

  // One-hot decode of the current index; all zero once idx reaches Num_Dst.
  always_comb begin
    w_sel     = '0;
    w_cur_cnt = '0;
    for (int d = 0; d < Num_Dst; d++) begin
      if (r_idx == Idx_W'(d)) begin
        w_sel[d]  = 1'b1;
        w_cur_cnt = r_cnt[d*Cnt_Width +: Cnt_Width];
      end
    end
  end

  assign w_route     = (r_state == S_ROUTE);
  assign w_idx_end   = (r_idx == Idx_W'(Num_Dst));
  assign w_last_beat = (r_remain == Cnt_Width'(1));

  assign s_axis_tready = w_route & (|(w_sel & m_axis_tready));
  assign w_hs          = s_axis_tvalid & s_axis_tready;

  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tvalid = (w_route && s_axis_tvalid) ? w_sel : '0;
  assign m_axis_tlast  = (w_route && w_last_beat)   ? w_sel : '0;

  assign dst_sel    = r_idx;
  assign busy       = (r_state != S_IDLE);
  assign layer_done = (r_state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_remain <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (layer_start) begin
            r_cnt   <= beat_cnt;
            r_idx   <= '0;
            r_state <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (w_idx_end) begin
            r_state <= S_DONE;
          end else if (w_cur_cnt == '0) begin
            r_idx <= r_idx + Idx_W'(1);
          end else begin
            r_remain <= w_cur_cnt;
            r_state  <= S_ROUTE;
          end
        end
        S_ROUTE: begin
          // Leaving at remain==1 keeps the counter from ever wrapping.
          if (w_hs) begin
            r_remain <= r_remain - Cnt_Width'(1);
            if (w_last_beat) begin
              r_idx   <= r_idx + Idx_W'(1);
              r_state <= S_SCAN;
            end
          end
        end
        S_DONE: begin
          r_idx   <= '0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_buff_load_scheduler.sv
// Directed bench for buff_load_scheduler: cycle-exact schedule checks plus per-destination handshake counters.
module tb_buff_load_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        layer_start;
  logic [63:0] beat_cnt;
  logic [63:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic [63:0] m_tdata;
  logic [3:0]  m_tvalid;
  logic [3:0]  m_tready;
  logic [3:0]  m_tlast;
  logic [2:0]  dst_sel;
  logic        busy;
  logic        layer_done;

  int errors = 0;
  int checks = 0;

  int hs[4], lst[4], tv_seen[4];
  int done_n = 0, rdy_seen = 0;
  int b_hs[4], b_lst[4], b_tv[4];
  int b_done, b_rdy;
  logic [63:0] dq[$];

  always #5 clk = ~clk;

  buff_load_scheduler #(.Axi_Width(64), .Num_Dst(4), .Cnt_Width(16)) dut (
    .clk(clk), .rst(rst), .layer_start(layer_start), .beat_cnt(beat_cnt),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast), .dst_sel(dst_sel), .busy(busy), .layer_done(layer_done)
  );

  initial begin
    for (int d = 0; d < 4; d++) begin
      hs[d] = 0; lst[d] = 0; tv_seen[d] = 0;
    end
  end

  // Mid-cycle observer: inputs change just after posedge, so negedge sees settled handshakes.
  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 4; d++) begin
        if (m_tvalid[d] && m_tready[d]) begin
          hs[d]++;
          if (m_tlast[d]) lst[d]++;
          if (d == 2) dq.push_back(m_tdata);
        end
        if (m_tvalid[d]) tv_seen[d]++;
      end
      if (layer_done) done_n++;
      if (s_tready) rdy_seen++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_cyc(input string tag, input logic b, input int sel, input logic rdy,
                            input logic [3:0] tv, input logic [3:0] tl, input logic dn);
    chk({tag, "_busy"}, busy, b);
    chk({tag, "_dst_sel"}, dst_sel, sel);
    chk({tag, "_s_tready"}, s_tready, rdy);
    chk({tag, "_m_tvalid"}, m_tvalid, tv);
    chk({tag, "_m_tlast"}, m_tlast, tl);
    chk({tag, "_layer_done"}, layer_done, dn);
  endtask

  task automatic snap();
    for (int d = 0; d < 4; d++) begin
      b_hs[d] = hs[d]; b_lst[d] = lst[d]; b_tv[d] = tv_seen[d];
    end
    b_done = done_n;
    b_rdy  = rdy_seen;
    dq.delete();
  endtask

  // Expects one SCAN cycle at index d followed by n back-to-back ROUTE beats.
  task automatic run_dst(input int d, input int n);
    logic [3:0] oh;
    oh = 4'b0001 << d;
    expect_cyc($sformatf("scan%0d", d), 1'b1, d, 1'b0, 4'b0, 4'b0, 1'b0);
    tick();
    for (int i = 1; i <= n; i++) begin
      expect_cyc($sformatf("route%0d_b%0d", d, i), 1'b1, d, 1'b1, oh, (i == n) ? oh : 4'b0, 1'b0);
      tick();
    end
  endtask

  task automatic start_layer(input logic [63:0] cnts);
    beat_cnt    = cnts;
    layer_start = 1'b1;
    tick();
    layer_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (!layer_done && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_done_seen"}, layer_done, 1'b1);
    tick();
  endtask

  initial begin
    logic [3:0]  pat;
    logic [63:0] seq;
    int          cyc;
    int          n;

    rst = 1'b1; layer_start = 1'b1; beat_cnt = 64'h0004_0002_0003_0005;
    s_tdata = 64'hA5; s_tvalid = 1'b1; m_tready = 4'hF;
    tick(); tick();
    expect_cyc("reset", 1'b0, 0, 1'b0, 4'b0, 4'b0, 1'b0);
    rst = 1'b0; layer_start = 1'b0;
    tick();
    expect_cyc("post_reset", 1'b0, 0, 1'b0, 4'b0, 4'b0, 1'b0);

    // Basic schedule: dst0..3 get 5,3,2,4 beats.
    snap();
    start_layer(64'h0004_0002_0003_0005);
    run_dst(0, 5);
    run_dst(1, 3);
    run_dst(2, 2);
    run_dst(3, 4);
    expect_cyc("scan_end", 1'b1, 4, 1'b0, 4'b0, 4'b0, 1'b0);
    tick();
    expect_cyc("done", 1'b1, 4, 1'b0, 4'b0, 4'b0, 1'b1);
    tick();
    expect_cyc("idle", 1'b0, 0, 1'b0, 4'b0, 4'b0, 1'b0);
    chk("shared_tdata", m_tdata, s_tdata);
    chk("basic_hs0", hs[0] - b_hs[0], 5);
    chk("basic_hs1", hs[1] - b_hs[1], 3);
    chk("basic_hs2", hs[2] - b_hs[2], 2);
    chk("basic_hs3", hs[3] - b_hs[3], 4);
    for (int d = 0; d < 4; d++) chk($sformatf("basic_last%0d", d), lst[d] - b_lst[d], 1);
    chk("basic_done_once", done_n - b_done, 1);

    // Zero-skip: every index scanned, nothing routed.
    snap();
    start_layer(64'h0);
    for (int d = 0; d <= 4; d++) begin
      expect_cyc($sformatf("zscan%0d", d), 1'b1, d, 1'b0, 4'b0, 4'b0, 1'b0);
      tick();
    end
    expect_cyc("zdone", 1'b1, 4, 1'b0, 4'b0, 4'b0, 1'b1);
    tick();
    expect_cyc("zidle", 1'b0, 0, 1'b0, 4'b0, 4'b0, 1'b0);
    chk("zero_no_hs", hs[0] + hs[1] + hs[2] + hs[3] - b_hs[0] - b_hs[1] - b_hs[2] - b_hs[3], 0);
    chk("zero_rdy_low", rdy_seen - b_rdy, 0);
    chk("zero_done_once", done_n - b_done, 1);

    // Partial skip: only dst0 and dst3 carry one beat each.
    snap();
    start_layer(64'h0001_0000_0000_0001);
    run_dst(0, 1);
    expect_cyc("pskip1", 1'b1, 1, 1'b0, 4'b0, 4'b0, 1'b0);
    tick();
    expect_cyc("pskip2", 1'b1, 2, 1'b0, 4'b0, 4'b0, 1'b0);
    tick();
    run_dst(3, 1);
    wait_done("partial", 10);
    chk("partial_hs0", hs[0] - b_hs[0], 1);
    chk("partial_hs3", hs[3] - b_hs[3], 1);
    chk("partial_last0", lst[0] - b_lst[0], 1);
    chk("partial_last3", lst[3] - b_lst[3], 1);
    chk("partial_tv1", tv_seen[1] - b_tv[1], 0);
    chk("partial_tv2", tv_seen[2] - b_tv[2], 0);

    // Backpressure on dst2 with random upstream valid.
    snap();
    pat = 4'b1001;
    seq = 64'd100;
    cyc = 0;
    n   = 0;
    start_layer(64'h0000_0004_0000_0000);
    while (!layer_done && n < 200) begin
      m_tready = {1'b1, pat[cyc % 4], 2'b11};
      s_tvalid = 1'($urandom_range(0, 1));
      s_tdata  = seq;
      #1;
      chk("bp_tdata_shared", m_tdata, s_tdata);
      if (!m_tready[2]) chk("bp_no_accept_blocked", s_tready, 1'b0);
      if (s_tvalid && s_tready) seq = seq + 64'd1;
      cyc++;
      n++;
      tick();
    end
    chk("bp_done_seen", layer_done, 1'b1);
    tick();
    m_tready = 4'hF; s_tvalid = 1'b1;
    chk("bp_beats", dq.size(), 4);
    chk("bp_seq_end", seq, 64'd104);
    for (int i = 0; i < 4; i++) chk($sformatf("bp_data%0d", i), (i < dq.size()) ? dq[i] : 64'hX, 64'd100 + 64'(i));
    chk("bp_last2", lst[2] - b_lst[2], 1);

    // Start while busy is ignored; next start uses new counts.
    snap();
    start_layer(64'h0000_0000_0000_0003);
    tick();
    beat_cnt = 64'h0000_0000_0002_0000;
    layer_start = 1'b1;
    tick();
    layer_start = 1'b0;
    wait_done("busy_start", 20);
    chk("busy_start_hs0", hs[0] - b_hs[0], 3);
    chk("busy_start_hs1", hs[1] - b_hs[1], 0);
    chk("busy_start_done", done_n - b_done, 1);
    snap();
    start_layer(64'h0000_0000_0002_0000);
    wait_done("new_start", 20);
    chk("new_start_hs0", hs[0] - b_hs[0], 0);
    chk("new_start_hs1", hs[1] - b_hs[1], 2);

    // Reset after 2 of 5 dst0 beats abandons the layer.
    snap();
    start_layer(64'h0000_0000_0000_0005);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_cyc("rst_mid", 1'b0, 0, 1'b0, 4'b0, 4'b0, 1'b0);
    tick(); tick(); tick();
    chk("rst_mid_hs0", hs[0] - b_hs[0], 2);
    chk("rst_mid_no_done", done_n - b_done, 0);
    snap();
    start_layer(64'h0004_0002_0003_0005);
    wait_done("rst_fresh", 40);
    chk("fresh_hs0", hs[0] - b_hs[0], 5);
    chk("fresh_hs1", hs[1] - b_hs[1], 3);
    chk("fresh_hs2", hs[2] - b_hs[2], 2);
    chk("fresh_hs3", hs[3] - b_hs[3], 4);
    chk("fresh_done", done_n - b_done, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
